// File: rtl/traffic_conflict_monitor.sv
// Receive-side safety monitor for the traffic-light aspect bus: flags illegal encodings, conflicts,
// bad aspect sequences and short yellows, then holds all lamps in flashing red until cleared.
//
// state    | meaning
// ST_ARM   | one cycle after reset/clear; establishes baseline aspects, checks encoding and conflicts only
// ST_RUN   | normal monitoring, all checks active, lamps follow the sampled bus
// ST_FAULT | cause latched, lamps flash red/off until clear_fault with an all-red bus
module traffic_conflict_monitor #(
  parameter int NUM_LIGHTS = 8,
  parameter logic [NUM_LIGHTS*NUM_LIGHTS-1:0] PERMIT_MASK = 64'hA050_A050_0906_0609,
  parameter int MIN_YELLOW = 2,
  parameter int FLASH_HALF = 4,
  parameter int CNT_W      = 8,
  localparam int LW = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3*NUM_LIGHTS-1:0] lights_in,
  input  logic                    clear_fault,
  output logic [3*NUM_LIGHTS-1:0] lamp_out,
  output logic                    fault,
  output logic [2:0]              fault_code,
  output logic [LW-1:0]           fault_light,
  output logic [CNT_W-1:0]        fault_count
);

  localparam int DW = (MIN_YELLOW > 0) ? $clog2(MIN_YELLOW + 1) : 1;
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [DW-1:0] DWELL_MAX  = DW'(MIN_YELLOW);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] ASP_R = 3'b100;
  localparam logic [2:0] ASP_Y = 3'b010;
  localparam logic [2:0] ASP_G = 3'b001;
  localparam logic [3*NUM_LIGHTS-1:0] ALL_RED = {NUM_LIGHTS{ASP_R}};

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_ILLEGAL  = 3'd1;
  localparam logic [2:0] CODE_CONFLICT = 3'd2;
  localparam logic [2:0] CODE_SEQUENCE = 3'd3;
  localparam logic [2:0] CODE_SHORT_Y  = 3'd4;

  typedef enum logic [1:0] {ST_ARM, ST_RUN, ST_FAULT} state_t;

  state_t                  state_q, state_d;
  logic [3*NUM_LIGHTS-1:0] lights_q, lights_d;
  logic [3*NUM_LIGHTS-1:0] prev_q, prev_d;
  logic [DW-1:0]           dwell_q [NUM_LIGHTS];
  logic [DW-1:0]           dwell_d [NUM_LIGHTS];
  logic [3*NUM_LIGHTS-1:0] lamp_q, lamp_d;
  logic                    fault_q, fault_d;
  logic [2:0]              code_q, code_d;
  logic [LW-1:0]           light_q, light_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    phase_q, phase_d;
  logic [FW-1:0]           flash_q, flash_d;

  logic          ill_hit, con_hit, seq_hit, shy_hit;
  logic [LW-1:0] ill_idx, con_idx, seq_idx, shy_idx;
  logic          run_viol, arm_viol;
  logic [2:0]    viol_code;
  logic [LW-1:0] viol_idx;

  // Per-light checks; each category keeps only its lowest offending index.
  always_comb begin
    logic [2:0] cur;
    logic [2:0] prv;
    cur     = '0;
    prv     = '0;
    ill_hit = 1'b0;
    con_hit = 1'b0;
    seq_hit = 1'b0;
    shy_hit = 1'b0;
    ill_idx = '0;
    con_idx = '0;
    seq_idx = '0;
    shy_idx = '0;
    dwell_d = dwell_q;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      cur = lights_q[3*i +: 3];
      prv = prev_q[3*i +: 3];
      if (!ill_hit && !(cur == ASP_R || cur == ASP_Y || cur == ASP_G)) begin
        ill_hit = 1'b1;
        ill_idx = LW'(i);
      end
      for (int j = 0; j < NUM_LIGHTS; j++) begin
        if (!con_hit && (j != i) && (cur != ASP_R) && (lights_q[3*j +: 3] != ASP_R) &&
            !(PERMIT_MASK[i*NUM_LIGHTS+j] && PERMIT_MASK[j*NUM_LIGHTS+i])) begin
          con_hit = 1'b1;
          con_idx = LW'(i);
        end
      end
      if (!seq_hit && ((prv == ASP_G && cur == ASP_R) || (prv == ASP_R && cur == ASP_Y) ||
                       (prv == ASP_Y && cur == ASP_G))) begin
        seq_hit = 1'b1;
        seq_idx = LW'(i);
      end
      if (!shy_hit && prv == ASP_Y && cur == ASP_R && dwell_q[i] < DWELL_MAX) begin
        shy_hit = 1'b1;
        shy_idx = LW'(i);
      end
      if (cur != prv)
        dwell_d[i] = DW'(1);
      else if (dwell_q[i] < DWELL_MAX)
        dwell_d[i] = dwell_q[i] + 1'b1;
    end
  end

  always_comb begin
    run_viol  = 1'b1;
    viol_code = CODE_NONE;
    viol_idx  = '0;
    if (ill_hit) begin
      viol_code = CODE_ILLEGAL;
      viol_idx  = ill_idx;
    end else if (con_hit) begin
      viol_code = CODE_CONFLICT;
      viol_idx  = con_idx;
    end else if (seq_hit) begin
      viol_code = CODE_SEQUENCE;
      viol_idx  = seq_idx;
    end else if (shy_hit) begin
      viol_code = CODE_SHORT_Y;
      viol_idx  = shy_idx;
    end else begin
      run_viol = 1'b0;
    end
    // Encoding and conflict outrank the rest, so viol_code is already right for ARM.
    arm_viol = ill_hit | con_hit;
  end

  always_comb begin
    logic go_fault;
    go_fault = 1'b0;
    state_d  = state_q;
    lights_d = lights_in;
    prev_d   = lights_q;
    lamp_d   = lamp_q;
    fault_d  = fault_q;
    code_d   = code_q;
    light_d  = light_q;
    count_d  = count_q;
    phase_d  = phase_q;
    flash_d  = flash_q;
    case (state_q)
      ST_ARM: begin
        if (arm_viol) begin
          go_fault = 1'b1;
        end else begin
          state_d = ST_RUN;
          lamp_d  = lights_q;
        end
      end
      ST_RUN: begin
        if (run_viol) go_fault = 1'b1;
        else          lamp_d   = lights_q;
      end
      ST_FAULT: begin
        if (clear_fault && lights_q == ALL_RED) begin
          state_d = ST_ARM;
          fault_d = 1'b0;
          code_d  = CODE_NONE;
          light_d = '0;
          lamp_d  = ALL_RED;
          phase_d = 1'b1;
          flash_d = FLASH_LOAD;
        end else if (flash_q == '0) begin
          phase_d = ~phase_q;
          flash_d = FLASH_LOAD;
          lamp_d  = phase_q ? '0 : ALL_RED;
        end else begin
          flash_d = flash_q - 1'b1;
        end
      end
      default: state_d = ST_ARM;
    endcase
    if (go_fault) begin
      state_d = ST_FAULT;
      fault_d = 1'b1;
      code_d  = viol_code;
      light_d = viol_idx;
      count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
      lamp_d  = ALL_RED;
      phase_d = 1'b1;
      flash_d = FLASH_LOAD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ARM;
      lights_q <= ALL_RED;
      prev_q   <= ALL_RED;
      for (int i = 0; i < NUM_LIGHTS; i++) dwell_q[i] <= '0;
      lamp_q   <= ALL_RED;
      fault_q  <= 1'b0;
      code_q   <= CODE_NONE;
      light_q  <= '0;
      count_q  <= '0;
      phase_q  <= 1'b1;
      flash_q  <= FLASH_LOAD;
    end else begin
      state_q  <= state_d;
      lights_q <= lights_d;
      prev_q   <= prev_d;
      dwell_q  <= dwell_d;
      lamp_q   <= lamp_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      light_q  <= light_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
      flash_q  <= flash_d;
    end
  end

  assign lamp_out    = lamp_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign fault_light = light_q;
  assign fault_count = count_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: scoreboard of expected lamp/fault outputs two cycles after each
// driven sample, plus scenario tasks with direct checks of fault latching, clearing and counting.
module tb_traffic_conflict_monitor;
  localparam logic [23:0] RED   = 24'h924924;
  localparam logic [2:0]  A_R   = 3'b100;
  localparam logic [2:0]  A_Y   = 3'b010;
  localparam logic [2:0]  A_G   = 3'b001;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] lights_in;
  logic        clear_fault;
  logic [23:0] lamp_out;
  logic        fault;
  logic [2:0]  fault_code;
  logic [2:0]  fault_light;
  logic [7:0]  fault_count;

  traffic_conflict_monitor dut (
    .clk(clk), .reset(reset), .lights_in(lights_in), .clear_fault(clear_fault),
    .lamp_out(lamp_out), .fault(fault), .fault_code(fault_code),
    .fault_light(fault_light), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [23:0] lamp;
    logic        flt;
    logic [2:0]  code;
    logic [2:0]  lt;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   exp_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.due != cyc) begin
        failures++; $display("FAIL sb_timing got_cycle=%0d exp_cycle=%0d", cyc, e.due);
      end
      checks++;
      if (lamp_out !== e.lamp) begin
        failures++; $display("FAIL sb_lamp cyc=%0d got=%h exp=%h", cyc, lamp_out, e.lamp);
      end
      checks++;
      if (fault !== e.flt) begin
        failures++; $display("FAIL sb_fault cyc=%0d got=%b exp=%b", cyc, fault, e.flt);
      end
      checks++;
      if (fault_code !== e.code) begin
        failures++; $display("FAIL sb_code cyc=%0d got=%0d exp=%0d", cyc, fault_code, e.code);
      end
      checks++;
      if (fault_light !== e.lt) begin
        failures++; $display("FAIL sb_light cyc=%0d got=%0d exp=%0d", cyc, fault_light, e.lt);
      end
    end
  end

  function automatic logic [23:0] with_asp(input logic [23:0] base, input int idx, input logic [2:0] asp);
    logic [23:0] r;
    r = base;
    r[3*idx +: 3] = asp;
    return r;
  endfunction

  task automatic drive(input logic [23:0] lin, input logic [23:0] lamp, input logic flt,
                       input logic [2:0] code, input logic [2:0] lt);
    @(negedge clk);
    lights_in = lin;
    sb.push_back('{due: cyc + 2, lamp: lamp, flt: flt, code: code, lt: lt});
  endtask

  // Lets pending expectations drain, then issues a clear with an all-red bus and waits out ARM.
  task automatic do_clear();
    repeat (2) begin
      @(negedge clk);
      lights_in = RED;
    end
    @(negedge clk);
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lights_in = RED;
    clear_fault = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (lamp_out !== RED) begin failures++; $display("FAIL reset_lamp got=%h exp=%h", lamp_out, RED); end
    checks++;
    if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++;
    if (fault_code !== 3'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", fault_code); end
    checks++;
    if (fault_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fault_count); end
    reset = 1'b0;
  endtask

  task automatic test_normal();
    logic [2:0] seq [11];
    logic [23:0] s;
    seq = '{A_R, A_R, A_R, A_G, A_G, A_G, A_Y, A_Y, A_R, A_R, A_R};
    for (int k = 0; k < 11; k++) begin
      s = with_asp(RED, 0, seq[k]);
      drive(s, s, 1'b0, 3'd0, 3'd0);
    end
    drive(RED, RED, 1'b0, 3'd0, 3'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (fault_count !== 8'd0) begin failures++; $display("FAIL normal_count got=%0d exp=0", fault_count); end
  endtask

  task automatic test_conflict();
    logic [23:0] x;
    x = with_asp(with_asp(RED, 0, A_G), 1, A_G);
    drive(x, RED, 1'b1, 3'd2, 3'd0);
    exp_count++;
    for (int k = 1; k <= 12; k++)
      drive(RED, (((k / 4) % 2) == 1) ? 24'h000000 : RED, 1'b1, 3'd2, 3'd0);
    checks++;
    if (fault_count !== 8'(exp_count)) begin
      failures++; $display("FAIL conflict_count got=%0d exp=%0d", fault_count, exp_count);
    end
    do_clear();
    checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || fault_light !== 3'd0) begin
      failures++; $display("FAIL conflict_clear got=%b/%0d/%0d exp=0/0/0", fault, fault_code, fault_light);
    end
  endtask

  task automatic test_illegal();
    logic [23:0] x1, x2;
    x1 = with_asp(RED, 0, A_G);
    x2 = with_asp(x1, 2, 3'b011);
    drive(x1, x1, 1'b0, 3'd0, 3'd0);
    drive(x2, RED, 1'b1, 3'd1, 3'd2);
    exp_count++;
    for (int k = 1; k <= 3; k++) drive(RED, RED, 1'b1, 3'd1, 3'd2);
    do_clear();
    checks++;
    if (fault_count !== 8'(exp_count)) begin
      failures++; $display("FAIL illegal_count got=%0d exp=%0d", fault_count, exp_count);
    end
  endtask

  task automatic test_sequence();
    logic [23:0] g5, g1, y1;
    g5 = with_asp(RED, 5, A_G);
    drive(g5, g5, 1'b0, 3'd0, 3'd0);
    drive(RED, RED, 1'b1, 3'd3, 3'd5);
    exp_count++;
    for (int k = 1; k <= 2; k++) drive(RED, RED, 1'b1, 3'd3, 3'd5);
    do_clear();
    g1 = with_asp(RED, 1, A_G);
    y1 = with_asp(RED, 1, A_Y);
    drive(g1, g1, 1'b0, 3'd0, 3'd0);
    drive(y1, y1, 1'b0, 3'd0, 3'd0);
    drive(RED, RED, 1'b1, 3'd4, 3'd1);
    exp_count++;
    for (int k = 1; k <= 2; k++) drive(RED, RED, 1'b1, 3'd4, 3'd1);
    do_clear();
    checks++;
    if (fault_count !== 8'(exp_count)) begin
      failures++; $display("FAIL sequence_count got=%0d exp=%0d", fault_count, exp_count);
    end
  endtask

  task automatic test_clear();
    logic [23:0] x, g3;
    x  = with_asp(with_asp(RED, 0, A_G), 1, A_G);
    g3 = with_asp(RED, 3, A_G);
    drive(x, RED, 1'b1, 3'd2, 3'd0);
    exp_count++;
    drive(g3, RED, 1'b1, 3'd2, 3'd0);
    @(negedge clk);
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    lights_in = RED;
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd2) begin
      failures++; $display("FAIL clear_ignored got=%b/%0d exp=1/2", fault, fault_code);
    end
    do_clear();
    checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0) begin
      failures++; $display("FAIL clear_exit got=%b/%0d exp=0/0", fault, fault_code);
    end
    checks++;
    if (fault_count !== 8'(exp_count)) begin
      failures++; $display("FAIL clear_count got=%0d exp=%0d", fault_count, exp_count);
    end
  endtask

  task automatic test_saturate();
    logic [23:0] x;
    x = with_asp(with_asp(RED, 0, A_G), 1, A_G);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk); lights_in = x;
      @(negedge clk); lights_in = RED;
      @(negedge clk); clear_fault = 1'b1;
      @(negedge clk); clear_fault = 1'b0;
      exp_count = (exp_count < 255) ? exp_count + 1 : 255;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (fault_count !== 8'(exp_count) || exp_count != 255) begin
      failures++; $display("FAIL saturate_count got=%0d exp=%0d", fault_count, 255);
    end
    checks++;
    if (fault !== 1'b0) begin failures++; $display("FAIL saturate_fault got=%b exp=0", fault); end
  endtask

  task automatic test_reset_mid_flash();
    @(negedge clk); lights_in = with_asp(with_asp(RED, 0, A_G), 1, A_G);
    @(negedge clk); lights_in = RED;
    repeat (6) @(negedge clk);
    checks++;
    if (fault !== 1'b1 || lamp_out !== 24'h000000) begin
      failures++; $display("FAIL flash_before_reset got=%b/%h exp=1/000000", fault, lamp_out);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (lamp_out !== RED || fault !== 1'b0 || fault_code !== 3'd0 || fault_light !== 3'd0 ||
        fault_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_flash got=%h/%b/%0d/%0d/%0d exp=%h/0/0/0/0",
               lamp_out, fault, fault_code, fault_light, fault_count, RED);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d limit=200000ns", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_normal();
    test_conflict();
    test_illegal();
    test_sequence();
    test_clear();
    test_saturate();
    test_reset_mid_flash();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
